idiv_fu_ctrl: RTL and testbench

Iterative RV32M divide functional unit with its own sequencing controller. Sits in the execute stage beside the single-cycle ALU functional unit. Accepts DIV/DIVU/REM/REMU operations over a valid/ready handshake, runs a restoring radix-2 division over XLEN cycles, and returns the result with the destination register address. The execute stage stalls on `req_ready_out`/`rsp_valid_out` and uses `flush_in` to kill in-flight work on a pipeline flush.

---
 rtl/cpu_params_pkg.sv | 15 +
 rtl/cpu_structs_pkg.sv | 42 ++++
 rtl/idiv_step.sv | 41 ++++
 rtl/idiv_fu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_idiv_fu_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// ---------------------------------------------------------------------------
// cpu_params_pkg
// Machine-wide numeric parameters shared by the execute-stage units.
//   XLEN     : integer register / operand width
//   CNT_W    : width of the divide iteration counter ($clog2(XLEN))
//   CNT_LAST : counter value at which the last restoring step happens
// ---------------------------------------------------------------------------
package cpu_params_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

endpackage : cpu_params_pkg

// File: rtl/cpu_structs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_structs_pkg
// Shared enumerations for the iterative divide unit plus small decode helpers.
//   DIV_OP_E     : request operation encoding (matches req_op_in)
//   IDIV_STATE_E : sequencing controller states
// ---------------------------------------------------------------------------
package cpu_structs_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } DIV_OP_E;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } IDIV_STATE_E;

    // Signed variants work on magnitudes and fix the sign up afterwards.
    function automatic logic op_is_signed(input DIV_OP_E op);
        logic res;
        case (op)
            DIV, REM: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    // Remainder variants return the remainder rather than the quotient.
    function automatic logic op_is_rem(input DIV_OP_E op);
        logic res;
        case (op)
            REM, REMU: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage : cpu_structs_pkg

// File: rtl/idiv_step.sv
// ---------------------------------------------------------------------------
// idiv_step
// One combinational restoring radix-2 division step.
//   rem      in  XLEN+1  partial remainder
//   quo      in  XLEN    dividend bits still to shift in / quotient bits so far
//   divisor  in  XLEN    divisor magnitude
//   rem_next out XLEN+1  partial remainder after this step
//   quo_next out XLEN    shifted quotient with the new bit in the LSB
// ---------------------------------------------------------------------------
module idiv_step
    import cpu_params_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;
    logic          ge_s;

    assign shifted_s = {rem[XLEN-1:0], quo[XLEN-1]};
    assign diff_s    = shifted_s - {1'b0, divisor};
    // The remainder top bit is always clear between steps; folding it into
    // the compare keeps the step correct even for an out-of-range input.
    assign ge_s      = rem[XLEN] | (shifted_s >= {1'b0, divisor});

    // Restore or keep the subtraction and shift the new quotient bit in.
    always_comb begin
        if (ge_s) begin
            rem_next = diff_s;
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s;
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule : idiv_step

// File: rtl/idiv_fu_ctrl.sv
// ---------------------------------------------------------------------------
// idiv_fu_ctrl
// Iterative RV32M divide functional unit (DIV/DIVU/REM/REMU) with its own
// IDLE/CALC/DONE sequencer. Restoring radix-2, one quotient bit per cycle.
//   clk_in, reset_in (sync, active-high), flush_in (kill in-flight work)
//   req_valid_in/req_ready_out, req_op_in, rs1_in, rs2_in, rd_addr_in
//   rsp_valid_out/rsp_ready_in, rsp_data_out, rsp_rd_addr_out
//   busy_out : controller is not IDLE
// Optional build macro IDIV_EARLY_OUT_EN: when |rs1| < |rs2| the result is
// known at accept time and the unit skips the CALC phase.
// ---------------------------------------------------------------------------
module idiv_fu_ctrl
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
(
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            flush_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [1:0]      req_op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      rd_addr_in,
    output logic            rsp_valid_out,
    input  logic            rsp_ready_in,
    output logic [XLEN-1:0] rsp_data_out,
    output logic [4:0]      rsp_rd_addr_out,
    output logic            busy_out
);

    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    IDIV_STATE_E     state_r,  state_nxt_s;
    DIV_OP_E         op_r,     op_nxt_s;
    DIV_OP_E         req_op_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [XLEN:0]   rem_r,    rem_nxt_s;
    logic [XLEN-1:0] quo_r,    quo_nxt_s;
    logic [XLEN-1:0] div_r,    div_nxt_s;
    logic [XLEN-1:0] result_r, result_nxt_s;
    logic [4:0]      rd_r,     rd_nxt_s;
    logic            q_neg_r,  q_neg_nxt_s;
    logic            r_neg_r,  r_neg_nxt_s;

    logic            accept_s;
    logic            signed_op_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] rs1_mag_s;
    logic [XLEN-1:0] rs2_mag_s;
    logic [XLEN:0]   step_rem_s;
    logic [XLEN-1:0] step_quo_s;
    logic [XLEN-1:0] q_fin_s;
    logic [XLEN-1:0] r_fin_s;

    assign req_op_s    = DIV_OP_E'(req_op_in);
    assign signed_op_s = op_is_signed(req_op_s);
    assign rs1_mag_s   = (signed_op_s && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
    assign rs2_mag_s   = (signed_op_s && rs2_in[XLEN-1]) ? -rs2_in : rs2_in;
    assign div_zero_s  = (rs2_in == ZERO_W);
    assign ovf_s       = signed_op_s && (rs1_in == MIN_NEG) && (rs2_in == ONES_W);

    assign req_ready_out   = (state_r == IDLE) && !flush_in;
    assign accept_s        = req_valid_in && req_ready_out;
    assign rsp_valid_out   = (state_r == DONE);
    assign busy_out        = (state_r != IDLE);
    assign rsp_data_out    = result_r;
    assign rsp_rd_addr_out = rd_r;

    idiv_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Signs are applied to the final step outputs so DONE is reached on the last CALC edge.
    assign q_fin_s = q_neg_r ? -step_quo_s : step_quo_s;
    assign r_fin_s = r_neg_r ? -(step_rem_s[XLEN-1:0]) : step_rem_s[XLEN-1:0];

    // Next-state and datapath-update decode for the sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        op_nxt_s     = op_r;
        count_nxt_s  = count_r;
        rem_nxt_s    = rem_r;
        quo_nxt_s    = quo_r;
        div_nxt_s    = div_r;
        result_nxt_s = result_r;
        rd_nxt_s     = rd_r;
        q_neg_nxt_s  = q_neg_r;
        r_neg_nxt_s  = r_neg_r;

        if (flush_in) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_nxt_s    = req_op_s;
                        rd_nxt_s    = rd_addr_in;
                        div_nxt_s   = rs2_mag_s;
                        quo_nxt_s   = rs1_mag_s;
                        rem_nxt_s   = {(XLEN+1){1'b0}};
                        count_nxt_s = {CNT_W{1'b0}};
                        q_neg_nxt_s = signed_op_s && (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]);
                        r_neg_nxt_s = signed_op_s && rs1_in[XLEN-1];
                        if (div_zero_s) begin
                            state_nxt_s  = DONE;
                            result_nxt_s = op_is_rem(req_op_s) ? rs1_in : ONES_W;
                        end else if (ovf_s) begin
                            state_nxt_s  = DONE;
                            result_nxt_s = op_is_rem(req_op_s) ? ZERO_W : MIN_NEG;
`ifdef IDIV_EARLY_OUT_EN
                        end else if (rs1_mag_s < rs2_mag_s) begin
                            // Quotient truncates to zero; remainder is the dividend itself.
                            state_nxt_s  = DONE;
                            result_nxt_s = op_is_rem(req_op_s) ? rs1_in : ZERO_W;
`endif
                        end else begin
                            state_nxt_s = CALC;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    rem_nxt_s   = step_rem_s;
                    quo_nxt_s   = step_quo_s;
                    count_nxt_s = count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        state_nxt_s  = DONE;
                        result_nxt_s = op_is_rem(op_r) ? r_fin_s : q_fin_s;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                DONE: begin
                    if (rsp_ready_in) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r  <= IDLE;
            op_r     <= DIV;
            count_r  <= {CNT_W{1'b0}};
            rem_r    <= {(XLEN+1){1'b0}};
            quo_r    <= ZERO_W;
            div_r    <= ZERO_W;
            result_r <= ZERO_W;
            rd_r     <= 5'd0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            op_r     <= op_nxt_s;
            count_r  <= count_nxt_s;
            rem_r    <= rem_nxt_s;
            quo_r    <= quo_nxt_s;
            div_r    <= div_nxt_s;
            result_r <= result_nxt_s;
            rd_r     <= rd_nxt_s;
            q_neg_r  <= q_neg_nxt_s;
            r_neg_r  <= r_neg_nxt_s;
        end
    end

endmodule : idiv_fu_ctrl

// File: tb/tb_idiv_fu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_idiv_fu_ctrl
// Directed-vector scoreboard bench for idiv_fu_ctrl. The stimulus process
// pushes the hand-computed result, rd and latency of every issued request;
// the monitor pops and compares when a response appears, checks that a
// back-pressured response stays stable, and that the unit is ready again the
// cycle after it retires. Latency of the |rs1|<|rs2| case follows the
// IDIV_EARLY_OUT_EN build macro.
// ---------------------------------------------------------------------------
module tb_idiv_fu_ctrl;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
`ifdef IDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [1:0]  req_op_in = 2'b00;
    logic [31:0] rs1_in = 32'd0;
    logic [31:0] rs2_in = 32'd0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        rsp_valid_out;
    logic        rsp_ready_in = 1'b1;
    logic [31:0] rsp_data_out;
    logic [4:0]  rsp_rd_addr_out;
    logic        busy_out;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    idiv_fu_ctrl dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .flush_in        (flush_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_op_in       (req_op_in),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .rd_addr_in      (rd_addr_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_ready_in    (rsp_ready_in),
        .rsp_data_out    (rsp_data_out),
        .rsp_rd_addr_out (rsp_rd_addr_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on first sight of a response, stability while held.
    bit          in_rsp = 1'b0;
    bit          chk_ready_next = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    string       cur_name = "";

    always @(negedge clk) begin
        if (chk_ready_next) begin
            check({cur_name, "_ready_after_retire"}, {31'd0, req_ready_out}, 32'd1);
            chk_ready_next = 1'b0;
        end
        if (!reset_in && rsp_valid_out) begin
            if (!in_rsp) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'd0, rsp_valid_out}, 32'd0);
                    cur_name = "unexpected";
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    cur_name = e.name;
                    check({e.name, "_data"}, rsp_data_out, e.data);
                    check({e.name, "_rd"}, {27'd0, rsp_rd_addr_out}, {27'd0, e.rd});
                    check({e.name, "_latency"}, cyc, e.acc + e.lat - 1);
                end
                held_data = rsp_data_out;
                held_rd   = rsp_rd_addr_out;
                in_rsp    = 1'b1;
            end else begin
                check({cur_name, "_hold_data"}, rsp_data_out, held_data);
                check({cur_name, "_hold_rd"}, {27'd0, rsp_rd_addr_out}, {27'd0, held_rd});
            end
            check({cur_name, "_ready_low_done"}, {31'd0, req_ready_out}, 32'd0);
            if (rsp_ready_in) begin
                in_rsp         = 1'b0;
                chk_ready_next = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready_out !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_ready", {31'd0, req_ready_out}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat, input bit push);
        exp_t e;
        wait_ready();
        req_valid_in = 1'b1;
        req_op_in    = op;
        rs1_in       = a;
        rs2_in       = b;
        rd_addr_in   = rd;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        if (push) begin
            e.data = exp;
            e.rd   = rd;
            e.lat  = lat;
            e.acc  = cyc;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_in = 1'b0;
        #1;
        check("rst_valid", {31'd0, rsp_valid_out}, 32'd0);
        check("rst_data", rsp_data_out, 32'd0);
        check("rst_rd", {27'd0, rsp_rd_addr_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_ready", {31'd0, req_ready_out}, 32'd1);
        @(posedge clk); #1;

        do_op("div_100_7",   OP_DIV,  32'd100,        32'd7,          5'd5,  32'd14,         33, 1'b1);
        do_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33, 1'b1);
        do_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33, 1'b1);
        do_op("div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd8,  32'hFFFF_FFFD,  33, 1'b1);
        do_op("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'd1,          33, 1'b1);
        do_op("div_m100_7",  OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFF2,  33, 1'b1);
        do_op("rem_m100_7",  OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd11, 32'hFFFF_FFFE,  33, 1'b1);
        do_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF,  32'd16,         5'd12, 32'h0FFF_FFFF,  33, 1'b1);
        do_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF,  32'd16,         5'd13, 32'd15,         33, 1'b1);
        do_op("divu_5_0",    OP_DIVU, 32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1,  1'b1);
        do_op("remu_5_0",    OP_REMU, 32'd5,          32'd0,          5'd15, 32'd5,          1,  1'b1);
        do_op("rem_m5_0",    OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd16, 32'hFFFF_FFFB,  1,  1'b1);
        do_op("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  1,  1'b1);
        do_op("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          1,  1'b1);
        do_op("divu_3_10",   OP_DIVU, 32'd3,          32'd10,         5'd19, 32'd0,          EO_LAT, 1'b1);
        do_op("remu_3_10",   OP_REMU, 32'd3,          32'd10,         5'd20, 32'd3,          EO_LAT, 1'b1);
        do_op("rem_m3_10",   OP_REM,  32'hFFFF_FFFD,  32'd10,         5'd21, 32'hFFFF_FFFD,  EO_LAT, 1'b1);

        // Backpressure: response held in DONE while the consumer stalls.
        wait_ready();
        rsp_ready_in = 1'b0;
        do_op("bp_divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd22, 32'hFFFF_FFFF, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_busy", {31'd0, busy_out}, 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready_in = 1'b1;

        // Flush ten cycles into CALC: the response must never appear.
        do_op("flushed", OP_DIV, 32'd100, 32'd7, 5'd23, 32'd0, 33, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush_in = 1'b1;
        #1 check("flush_ready_comb", {31'd0, req_ready_out}, 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0;
        #1;
        check("flush_ready_next", {31'd0, req_ready_out}, 32'd1);
        check("flush_busy_next", {31'd0, busy_out}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        do_op("after_flush", OP_DIV, 32'd100, 32'd7, 5'd24, 32'd14, 33, 1'b1);

        begin
            int n = 0;
            while ((sb.size() != 0 || rsp_valid_out) && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("drain", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_idiv_fu_ctrl
